// File: rtl/mysystem_sysid_pkg.sv
// Shared register map constants for the system-ID peripheral.
package mysystem_sysid_pkg;

    // Word offsets of the register map
    localparam logic [31:0] REG_ID        = 32'd0;
    localparam logic [31:0] REG_TS        = 32'd1;
    localparam logic [31:0] REG_INFO      = 32'd2;
    localparam logic [31:0] REG_SCRATCH   = 32'd3;
    localparam logic [31:0] REG_UPTIME_LO = 32'd4;
    localparam logic [31:0] REG_UPTIME_HI = 32'd5;
    localparam logic [31:0] REG_CTRL      = 32'd6;

    // CTRL bit positions
    localparam int CTRL_CLEAR_BIT  = 0;
    localparam int CTRL_FREEZE_BIT = 1;

    // INFO field positions: {VERSION, ADDR_W, 8'h00}
    localparam int INFO_VERSION_LSB = 16;
    localparam int INFO_ADDRW_LSB   = 8;

    // Byte-lane merge used for SCRATCH writes
    function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  be);
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) res[b*8 +: 8] = new_val[b*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/mysystem_sysid_uptime.sv
// Free-running 64-bit uptime counter advanced once every TICK_DIV clocks.
module mysystem_sysid_uptime
    import mysystem_sysid_pkg::*;
#(
    parameter int TICK_DIV = 50
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        clear,
    input  logic        freeze,
    output logic [63:0] count
);

    // A divide-by-1 still needs a 1-bit prescaler to keep widths legal
    localparam int            PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] r_presc;
    logic [63:0]   r_count;

    assign count = r_count;

    // Prescaler and counter; clear wins over a coincident tick, freeze holds both
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            r_presc <= '0;
            r_count <= '0;
        end else if (!freeze) begin
            if (r_presc == LAST) begin
                r_presc <= '0;
                r_count <= r_count + 64'd1;
            end else begin
                r_presc <= r_presc + PW'(1);
            end
        end
    end

endmodule

// File: rtl/mysystem_sysid_ext.sv
// System-ID peripheral: ID/timestamp/info, scratch, uptime with coherent hi/lo, control.
module mysystem_sysid_ext
    import mysystem_sysid_pkg::*;
#(
    parameter logic [31:0] SYSTEM_ID     = 32'h8765_4321,
    parameter logic [31:0] TIMESTAMP     = 32'd1766976583,
    parameter logic [15:0] VERSION       = 16'h0002,
    parameter int          ADDR_W        = 3,
    parameter int          TICK_DIV      = 50,
    parameter logic [31:0] SCRATCH_RESET = 32'h0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] address,
    input  logic              read,
    input  logic              write,
    input  logic [31:0]       writedata,
    input  logic [3:0]        byteenable,
    output logic [31:0]       readdata,
    output logic              readdatavalid
);

    localparam logic [31:0] INFO_VAL = (32'(VERSION) << INFO_VERSION_LSB)
                                     | (32'(8'(ADDR_W)) << INFO_ADDRW_LSB);

    logic [31:0] w_addr;
    logic        w_wr_scratch;
    logic        w_wr_ctrl;
    logic        w_clear;
    logic [63:0] w_count;
    logic [31:0] w_rdata;

    logic [31:0] r_scratch;
    logic        r_freeze;
    logic [31:0] r_hi_shadow;
    logic [31:0] r_readdata;
    logic        r_rdvalid;

    assign w_addr       = 32'(address);
    assign w_wr_scratch = write && (w_addr == REG_SCRATCH);
    assign w_wr_ctrl    = write && (w_addr == REG_CTRL);
    assign w_clear      = w_wr_ctrl && writedata[CTRL_CLEAR_BIT];

    assign readdata      = r_readdata;
    assign readdatavalid = r_rdvalid;

    mysystem_sysid_uptime #(
        .TICK_DIV (TICK_DIV)
    ) u_uptime (
        .clock  (clock),
        .reset  (reset),
        .clear  (w_clear),
        .freeze (r_freeze),
        .count  (w_count)
    );

    // Read mux on pre-write state, so a same-cycle read/write returns the old value
    always_comb begin
        w_rdata = '0;
        case (w_addr)
            REG_ID:        w_rdata = SYSTEM_ID;
            REG_TS:        w_rdata = TIMESTAMP;
            REG_INFO:      w_rdata = INFO_VAL;
            REG_SCRATCH:   w_rdata = r_scratch;
            REG_UPTIME_LO: w_rdata = w_count[31:0];
            REG_UPTIME_HI: w_rdata = r_hi_shadow;
            REG_CTRL:      w_rdata[CTRL_FREEZE_BIT] = r_freeze;
            default:       w_rdata = '0;
        endcase
    end

    // Software-writable state: SCRATCH with byte lanes, FREEZE bit
    always_ff @(posedge clock) begin
        if (reset) begin
            r_scratch <= SCRATCH_RESET;
            r_freeze  <= 1'b0;
        end else begin
            if (w_wr_scratch) r_scratch <= byte_merge(r_scratch, writedata, byteenable);
            if (w_wr_ctrl)    r_freeze  <= writedata[CTRL_FREEZE_BIT];
        end
    end

    // Upper half is latched on every LO read so a LO-then-HI pair is coherent
    always_ff @(posedge clock) begin
        if (reset) begin
            r_hi_shadow <= '0;
        end else if (read && (w_addr == REG_UPTIME_LO)) begin
            r_hi_shadow <= w_count[63:32];
        end
    end

    // Fixed one-cycle read pipeline; data holds until the next read
    always_ff @(posedge clock) begin
        if (reset) begin
            r_readdata <= '0;
            r_rdvalid  <= 1'b0;
        end else begin
            r_rdvalid <= read;
            if (read) r_readdata <= w_rdata;
        end
    end

endmodule

// File: tb/tb_mysystem_sysid_ext.sv
// Self-checking bench for mysystem_sysid_ext with a behavioural reference model.
module tb_mysystem_sysid_ext;

    localparam int TD = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  address = '0;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic [31:0] writedata = '0;
    logic [3:0]  byteenable = '0;
    logic [31:0] readdata;
    logic        readdatavalid;

    int n_chk  = 0;
    int n_fail = 0;

    mysystem_sysid_ext #(
        .TICK_DIV (TD)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .address       (address),
        .read          (read),
        .write         (write),
        .writedata     (writedata),
        .byteenable    (byteenable),
        .readdata      (readdata),
        .readdatavalid (readdatavalid)
    );

    always #5 clock = ~clock;

    // Reference model: uptime = base + (counting cycles since clear) / TD
    logic [63:0]     m_base = '0;
    longint unsigned m_run  = 0;
    logic            m_frz  = 1'b0;
    logic [31:0]     m_scr  = '0;
    logic [31:0]     m_hi   = '0;
    logic            m_load = 1'b0;

    function automatic logic [63:0] m_up();
        return m_base + 64'(m_run / TD);
    endfunction

    function automatic logic [31:0] m_read(input logic [2:0] a);
        logic [63:0] u;
        u = m_up();
        case (a)
            3'd0:    return 32'h8765_4321;
            3'd1:    return 32'd1766976583;
            3'd2:    return 32'h0002_0300;
            3'd3:    return m_scr;
            3'd4:    return u[31:0];
            3'd5:    return m_hi;
            3'd6:    return {30'b0, m_frz, 1'b0};
            default: return 32'h0;
        endcase
    endfunction

    // Model state update on every clock
    always @(posedge clock) begin
        logic [63:0] u;
        u = m_up();
        if (reset) begin
            m_base <= '0; m_run <= 0; m_frz <= 1'b0; m_scr <= '0; m_hi <= '0;
        end else begin
            if (m_load) begin
                m_base <= 64'h0000_0000_FFFF_FFFF; m_run <= 0;
            end else if (write && address == 3'd6 && writedata[0]) begin
                m_base <= '0; m_run <= 0;
            end else if (!m_frz) begin
                m_run <= m_run + 1;
            end
            if (write && address == 3'd6) m_frz <= writedata[1];
            if (write && address == 3'd3)
                for (int b = 0; b < 4; b++)
                    if (byteenable[b]) m_scr[b*8 +: 8] <= writedata[b*8 +: 8];
            if (read && address == 3'd4) m_hi <= u[63:32];
        end
    end

    task automatic cyc();
        @(posedge clock); #1;
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] d, output logic v);
        address = a; read = 1'b1;
        cyc();
        read = 1'b0;
        d = readdata; v = readdatavalid;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d, input logic [3:0] be);
        address = a; write = 1'b1; writedata = d; byteenable = be;
        cyc();
        write = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) cyc();
        n_chk++;
        if (readdata !== 32'h0 || readdatavalid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got data=%h valid=%b want 0/0", readdata, readdatavalid);
        end
        reset = 1'b0;
    endtask

    task automatic test_uptime();
        logic [31:0] d, exp;
        logic v;
        repeat (40) cyc();
        exp = m_read(3'd4);
        rd(3'd4, d, v);
        n_chk++;
        if (d !== 32'd10 || d !== exp || v !== 1'b1) begin
            n_fail++;
            $display("FAIL uptime_40clk: got %0d valid=%b want 10 (model %0d)", d, v, exp);
        end
        wr(3'd6, 32'h2, 4'h0);
        exp = m_read(3'd4);
        rd(3'd4, d, v);
        repeat (100) cyc();
        exp = m_read(3'd4);
        rd(3'd4, d, v);
        n_chk++;
        if (d !== exp) begin
            n_fail++;
            $display("FAIL uptime_frozen: got %0d want %0d", d, exp);
        end
        wr(3'd6, 32'h0, 4'h0);
        repeat (21) cyc();
        exp = m_read(3'd4);
        rd(3'd4, d, v);
        n_chk++;
        if (d !== exp) begin
            n_fail++;
            $display("FAIL uptime_resume: got %0d want %0d", d, exp);
        end
    endtask

    task automatic test_id();
        logic [31:0] d;
        logic v;
        for (int i = 0; i < 3; i++) begin
            rd(3'(i), d, v);
            n_chk++;
            if (v !== 1'b1 || d !== m_read(3'(i))) begin
                n_fail++;
                $display("FAIL id_word%0d: got %h valid=%b want %h valid=1", i, d, v, m_read(3'(i)));
            end
            cyc();
            n_chk++;
            if (readdatavalid !== 1'b0 || readdata !== d) begin
                n_fail++;
                $display("FAIL id_hold%0d: got valid=%b data=%h want valid=0 data=%h",
                         i, readdatavalid, readdata, d);
            end
        end
    endtask

    task automatic test_scratch();
        logic [31:0] d;
        logic v;
        wr(3'd3, 32'hDEAD_BEEF, 4'hF);
        rd(3'd3, d, v);
        n_chk++;
        if (d !== 32'hDEAD_BEEF) begin
            n_fail++; $display("FAIL scratch_full: got %h want deadbeef", d);
        end
        wr(3'd3, 32'h1122_3344, 4'b0101);
        rd(3'd3, d, v);
        n_chk++;
        if (d !== 32'hDE22_BE44) begin
            n_fail++; $display("FAIL scratch_be: got %h want de22be44", d);
        end
        address = 3'd3; read = 1'b1; write = 1'b1; writedata = 32'hCAFE_F00D; byteenable = 4'hF;
        cyc();
        read = 1'b0; write = 1'b0;
        n_chk++;
        if (readdata !== 32'hDE22_BE44) begin
            n_fail++; $display("FAIL scratch_rw_same: got %h want de22be44", readdata);
        end
        rd(3'd3, d, v);
        n_chk++;
        if (d !== 32'hCAFE_F00D) begin
            n_fail++; $display("FAIL scratch_after_rw: got %h want cafef00d", d);
        end
        wr(3'd0, 32'h0, 4'hF);
        rd(3'd0, d, v);
        n_chk++;
        if (d !== 32'h8765_4321) begin
            n_fail++; $display("FAIL ro_write_ignored: got %h want 87654321", d);
        end
    endtask

    task automatic test_carry();
        logic [31:0] d;
        logic v;
        wr(3'd6, 32'h3, 4'h0);
        force dut.u_uptime.r_count = 64'h0000_0000_FFFF_FFFF;
        m_load = 1'b1;
        cyc();
        release dut.u_uptime.r_count;
        m_load = 1'b0;
        wr(3'd6, 32'h0, 4'h0);
        repeat (TD - 1) cyc();
        rd(3'd4, d, v);
        n_chk++;
        if (d !== 32'hFFFF_FFFF) begin
            n_fail++; $display("FAIL carry_lo1: got %h want ffffffff", d);
        end
        rd(3'd5, d, v);
        n_chk++;
        if (d !== 32'h0) begin
            n_fail++; $display("FAIL carry_hi1: got %h want 00000000", d);
        end
        rd(3'd4, d, v);
        n_chk++;
        if (d !== 32'h0) begin
            n_fail++; $display("FAIL carry_lo2: got %h want 00000000", d);
        end
        rd(3'd5, d, v);
        n_chk++;
        if (d !== 32'h1) begin
            n_fail++; $display("FAIL carry_hi2: got %h want 00000001", d);
        end
    endtask

    task automatic test_clear();
        logic [31:0] d;
        logic v;
        int budget;
        budget = 0;
        while ((m_run % TD) != TD - 1 && budget < 20) begin
            cyc(); budget++;
        end
        n_chk++;
        if (budget >= 20) begin
            n_fail++; $display("FAIL clear_sync: no tick cycle within %0d cycles", budget);
        end
        wr(3'd6, 32'h1, 4'h0);
        rd(3'd5, d, v);
        n_chk++;
        if (d !== 32'h1) begin
            n_fail++; $display("FAIL clear_keeps_hi: got %h want 00000001", d);
        end
        rd(3'd4, d, v);
        n_chk++;
        if (d !== 32'h0) begin
            n_fail++; $display("FAIL clear_lo: got %h want 00000000", d);
        end
        wr(3'd6, 32'hFFFF_FFFE, 4'hF);
        rd(3'd6, d, v);
        n_chk++;
        if (d !== 32'h2) begin
            n_fail++; $display("FAIL ctrl_read: got %h want 00000002", d);
        end
        wr(3'd6, 32'h0, 4'h0);
        rd(3'd7, d, v);
        n_chk++;
        if (d !== 32'h0 || v !== 1'b1) begin
            n_fail++; $display("FAIL reserved_read: got %h valid=%b want 0 valid=1", d, v);
        end
    endtask

    task automatic test_random();
        logic [31:0] exp, last;
        logic        r_en;
        last = readdata;
        for (int i = 0; i < 300; i++) begin
            address    = 3'($urandom_range(0, 7));
            r_en       = 1'($urandom % 2);
            write      = ($urandom % 3) == 0;
            writedata  = $urandom;
            byteenable = 4'($urandom);
            if (address == 3'd6) writedata[0] = ($urandom % 8) == 0;
            read = r_en;
            exp  = r_en ? m_read(address) : last;
            cyc();
            read = 1'b0; write = 1'b0;
            n_chk++;
            if (readdatavalid !== r_en || readdata !== exp) begin
                n_fail++;
                $display("FAIL random[%0d] addr=%0d: got %h valid=%b want %h valid=%b",
                         i, address, readdata, readdatavalid, exp, r_en);
            end
            last = exp;
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        logic v;
        wr(3'd3, 32'h5555_AAAA, 4'hF);
        address = 3'd3; read = 1'b1; reset = 1'b1;
        cyc();
        read = 1'b0;
        n_chk++;
        if (readdatavalid !== 1'b0 || readdata !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_mid_read: got valid=%b data=%h want 0/0", readdatavalid, readdata);
        end
        reset = 1'b0;
        rd(3'd3, d, v);
        n_chk++;
        if (d !== 32'h0) begin
            n_fail++; $display("FAIL reset_scratch: got %h want 00000000", d);
        end
    endtask

    initial begin
        test_reset();
        test_uptime();
        test_id();
        test_scratch();
        test_carry();
        test_clear();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule
